// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage.
// State encoding, MEM/WB bundle and its bubble value.
package mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] rd_addr;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register.
// Sync reset; bubble_i loads an inert slot instead of d_i.
module mem_wb_register
  import mem_stage_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    bubble_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);

  mem_wb_t wb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q <= '0;
    end else if (bubble_i) begin
      wb_q <= MEM_WB_BUBBLE;
    end else begin
      wb_q <= d_i;
    end
  end

  assign q_o = wb_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access FSM feeding MEM/WB.
// Optional abort on a stuck access with `define MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [4:0]        RDaddr_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [4:0]        RDaddr_o,
  output logic              err_o
);
  import mem_stage_pkg::*;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;
  logic              load_q, load_d;
  logic [4:0]        rd_q, rd_d;
  logic              bubble;
  mem_wb_t           wb_d, wb_q;
  logic              access;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign access = MemRead_i | MemWrite_i;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    load_d  = load_q;
    rd_d    = rd_q;
    stall_o = 1'b0;
    bubble  = 1'b0;
    wb_d    = '{reg_write:  RegWrite_i,
                mem_to_reg: MemtoReg_i,
                read_data:  '0,
                alu_result: ALUResult_i,
                rd_addr:    RDaddr_i};
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          stall_o = 1'b1;
          bubble  = 1'b1;
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = ALUResult_i;
          wdata_d = RS2data_i;
          rw_d    = RegWrite_i;
          m2r_d   = MemtoReg_i;
          // both flags set behaves as a store
          load_d  = MemRead_i & ~MemWrite_i;
          rd_d    = RDaddr_i;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          wb_d    = '{reg_write:  rw_q,
                      mem_to_reg: m2r_q,
                      read_data:  load_q ? mem_rdata_i : '0,
                      alu_result: addr_q,
                      rd_addr:    rd_q};
        end else begin
          stall_o = 1'b1;
          bubble  = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            stall_o = 1'b0;
            state_d = ST_IDLE;
            req_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      load_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  mem_wb_register u_mem_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (bubble),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RegWrite_o  = wb_q.reg_write;
  assign MemtoReg_o  = wb_q.mem_to_reg;
  assign ReadData_o  = wb_q.read_data;
  assign ALUResult_o = wb_q.alu_result;
  assign RDaddr_o    = wb_q.rd_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage.
// Timeout case runs only with MEM_TIMEOUT_EN defined.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUResult_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALUResult_o;
  logic [4:0]  RDaddr_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUResult_i (ALUResult_i),
    .RS2data_i   (RS2data_i),
    .RDaddr_i    (RDaddr_i),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .ReadData_o  (ReadData_o),
    .ALUResult_o (ALUResult_o),
    .RDaddr_o    (RDaddr_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r,
                       input logic rd, input logic wr,
                       input logic [31:0] alu,
                       input logic [31:0] rs2,
                       input logic [4:0] rd_a);
    RegWrite_i  = rw;
    MemtoReg_i  = m2r;
    MemRead_i   = rd;
    MemWrite_i  = wr;
    ALUResult_i = alu;
    RS2data_i   = rs2;
    RDaddr_i    = rd_a;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    idle_in();
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_rw", 32'(RegWrite_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_alu", ALUResult_o, 32'h0);
    chk("rst_stall", 32'(stall_o), 32'd0);

    // 1: plain ALU op
    drive(1, 0, 0, 0, 32'h1234, 32'h0, 5'd5);
    #1 chk("alu_stall", 32'(stall_o), 32'd0);
    tick();
    chk("alu_res", ALUResult_o, 32'h1234);
    chk("alu_rd", 32'(RDaddr_o), 32'd5);
    chk("alu_rw", 32'(RegWrite_o), 32'd1);
    chk("alu_rdata", ReadData_o, 32'h0);

    // rd = x0 passes through
    drive(1, 0, 0, 0, 32'h77, 32'h0, 5'd0);
    tick();
    chk("x0_rw", 32'(RegWrite_o), 32'd1);
    chk("x0_rd", 32'(RDaddr_o), 32'd0);

    // 2: load, ack on 3rd WAIT cycle
    drive(1, 1, 1, 0, 32'h40, 32'h0, 5'd7);
    #1 chk("ld_stall0", 32'(stall_o), 32'd1);
    tick();
    chk("ld_req", 32'(mem_req_o), 32'd1);
    chk("ld_we", 32'(mem_we_o), 32'd0);
    chk("ld_addr", mem_addr_o, 32'h40);
    chk("ld_bub0", 32'(RegWrite_o), 32'd0);
    for (int i = 1; i < 3; i++) begin
      #1 chk("ld_stallw", 32'(stall_o), 32'd1);
      tick();
      chk("ld_bubw", 32'(RegWrite_o), 32'd0);
      chk("ld_reqw", 32'(mem_req_o), 32'd1);
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE0001;
    #1 chk("ld_stall_ack", 32'(stall_o), 32'd0);
    tick();
    mem_ack_i = 1'b0;
    idle_in();
    chk("ld_data", ReadData_o, 32'hCAFE0001);
    chk("ld_m2r", 32'(MemtoReg_o), 32'd1);
    chk("ld_rw", 32'(RegWrite_o), 32'd1);
    chk("ld_rd", 32'(RDaddr_o), 32'd7);
    chk("ld_alu", ALUResult_o, 32'h40);
    chk("ld_req_drop", 32'(mem_req_o), 32'd0);

    // 3: store, ack on first WAIT cycle
    drive(0, 0, 0, 1, 32'h80, 32'h55, 5'd9);
    tick();
    chk("st_we", 32'(mem_we_o), 32'd1);
    chk("st_addr", mem_addr_o, 32'h80);
    chk("st_wdata", mem_wdata_o, 32'h55);
    chk("st_req", 32'(mem_req_o), 32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h99;
    #1 chk("st_stall_ack", 32'(stall_o), 32'd0);
    tick();
    mem_ack_i = 1'b0;
    idle_in();
    chk("st_rw", 32'(RegWrite_o), 32'd0);
    chk("st_rdata", ReadData_o, 32'h0);
    chk("st_alu", ALUResult_o, 32'h80);
    chk("st_req_drop", 32'(mem_req_o), 32'd0);

    // read and write together: store semantics
    drive(1, 1, 1, 1, 32'hC0, 32'h66, 5'd2);
    tick();
    chk("rw_we", 32'(mem_we_o), 32'd1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b0;
    idle_in();
    chk("rw_rdata", ReadData_o, 32'h0);

    // 4: reset in WAIT, ack right after
    drive(1, 1, 1, 0, 32'h100, 32'h0, 5'd4);
    tick();
    chk("rs_req_pre", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle_in();
    chk("rs_req", 32'(mem_req_o), 32'd0);
    chk("rs_addr", mem_addr_o, 32'h0);
    chk("rs_rw", 32'(RegWrite_o), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1111;
    #1 chk("rs_stall", 32'(stall_o), 32'd0);
    tick();
    mem_ack_i = 1'b0;
    chk("rs_ack_req", 32'(mem_req_o), 32'd0);
    chk("rs_ack_rw", 32'(RegWrite_o), 32'd0);
    chk("rs_ack_data", ReadData_o, 32'h0);

    // 5: back-to-back loads
    drive(1, 1, 1, 0, 32'h200, 32'h0, 5'd3);
    tick();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h111;
    tick();
    mem_ack_i = 1'b0;
    drive(1, 1, 1, 0, 32'h204, 32'h0, 5'd4);
    chk("b2b_a_rw", 32'(RegWrite_o), 32'd1);
    chk("b2b_a_data", ReadData_o, 32'h111);
    #1 chk("b2b_b_stall", 32'(stall_o), 32'd1);
    tick();
    chk("b2b_nodup", 32'(RegWrite_o), 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h222;
    tick();
    mem_ack_i = 1'b0;
    idle_in();
    chk("b2b_b_rw", 32'(RegWrite_o), 32'd1);
    chk("b2b_b_data", ReadData_o, 32'h222);
    chk("b2b_b_rd", 32'(RDaddr_o), 32'd4);
    tick();
    chk("b2b_after", 32'(RegWrite_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // 6: no ack, abort after 4 WAIT cycles
    drive(1, 1, 1, 0, 32'h300, 32'h0, 5'd6);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to_req", 32'(mem_req_o), 32'd1);
      chk("to_err0", 32'(err_o), 32'd0);
      tick();
    end
    chk("to_req4", 32'(mem_req_o), 32'd1);
    #1 chk("to_stall", 32'(stall_o), 32'd0);
    tick();
    idle_in();
    chk("to_drop", 32'(mem_req_o), 32'd0);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_rw", 32'(RegWrite_o), 32'd0);
    tick();
    tick();
    chk("to_sticky", 32'(err_o), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
